// File: rtl/Thor2022_pkg.sv
// Thor2022_pkg
//   Types shared by the branch update queue and its storage.
//   Address       : instruction address type
//   BranchOutcome : one resolved branch {ip, takb, pred}
package Thor2022_pkg;

  localparam int ADDR_W = 32;

  typedef logic [ADDR_W-1:0] Address;

  typedef struct packed {
    Address ip;
    logic   takb;
    logic   pred;
  } BranchOutcome;

endpackage

// File: rtl/Thor2022_buq_ram.sv
// Thor2022_buq_ram
//   DEPTH x BranchOutcome storage for the branch update queue.
//   One synchronous write port and one asynchronous read port; no reset.
//   The pred bit is only kept when THOR2022_BUQ_STATS_EN is defined;
//   otherwise it reads back as 0.
// Ports:
//   clk      : clock
//   i_we     : write enable
//   i_waddr  : write index
//   i_wdata  : entry to write
//   i_raddr  : read index
//   o_rdata  : entry at i_raddr (combinational)
module Thor2022_buq_ram
  import Thor2022_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  BranchOutcome      i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output BranchOutcome      o_rdata
);

  Address r_ip   [DEPTH];
  logic   r_takb [DEPTH];
`ifdef THOR2022_BUQ_STATS_EN
  logic   r_pred [DEPTH];
`else
  logic   w_unused_pred;
  assign w_unused_pred = i_wdata.pred;
`endif

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_ip[i_waddr]   <= i_wdata.ip;
      r_takb[i_waddr] <= i_wdata.takb;
`ifdef THOR2022_BUQ_STATS_EN
      r_pred[i_waddr] <= i_wdata.pred;
`endif
    end
  end

  always_comb begin
    o_rdata      = '0;
    o_rdata.ip   = r_ip[i_raddr];
    o_rdata.takb = r_takb[i_raddr];
`ifdef THOR2022_BUQ_STATS_EN
    o_rdata.pred = r_pred[i_raddr];
`endif
  end

endmodule

// File: rtl/thor2022_branch_update_queue.sv
// thor2022_branch_update_queue
//   Holds resolved branches from execute until they commit, then feeds them
//   to the gselect predictor update port in program order, one per cycle.
//   Uncommitted entries are discarded on flush; committed ones always drain.
//   Pointers: hd = oldest, cp = oldest uncommitted, tl = next free.
//   Committed region [hd,cp), speculative region [cp,tl). Pointers carry one
//   extra MSB so that full and empty are distinguishable.
// Optional feature macro: THOR2022_BUQ_STATS_EN (adds upd_cnt / miss_cnt and
//   stores the predicted direction per entry).
// Ports:
//   clk, rst (sync, active-low)
//   en               : allow draining to the predictor
//   ex_v/ex_ip/ex_takb/ex_pred, ex_rdy : enqueue from execute
//   cmt, flush       : commit oldest uncommitted / discard uncommitted
//   xisBranch/xip/takb : registered update strobe and payload
//   count            : total occupancy
//   upd_cnt/miss_cnt : delivered updates / delivered mispredictions (stats)
module thor2022_branch_update_queue
  import Thor2022_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          ex_v,
  input  Address        ex_ip,
  input  logic          ex_takb,
  input  logic          ex_pred,
  output logic          ex_rdy,
  input  logic          cmt,
  input  logic          flush,
  output logic          xisBranch,
  output Address        xip,
  output logic          takb,
  output logic [CW-1:0] count
`ifdef THOR2022_BUQ_STATS_EN
  ,
  output logic [31:0]   upd_cnt,
  output logic [31:0]   miss_cnt
`endif
);

  localparam logic [CW-1:0] PTR_ONE = CW'(1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [CW-1:0] r_hd;
  logic [CW-1:0] r_cp;
  logic [CW-1:0] r_tl;

  logic          w_enq;
  logic          w_cmt;
  logic          w_drain;
  logic [CW-1:0] w_cp_nxt;
  BranchOutcome  w_wdata;
  BranchOutcome  w_rdata;

  assign count  = r_tl - r_hd;
  // Based on registered pointers only: a drain this cycle frees a slot next cycle.
  assign ex_rdy = (count < DEPTH_C);

  assign w_enq   = ex_v && ex_rdy && !flush;
  // An entry written this cycle sits at tl, so cp != tl already excludes it.
  assign w_cmt   = cmt && (r_cp != r_tl);
  assign w_drain = en && (r_hd != r_cp);

  assign w_cp_nxt = w_cmt ? (r_cp + PTR_ONE) : r_cp;

  always_comb begin
    w_wdata      = '0;
    w_wdata.ip   = ex_ip;
    w_wdata.takb = ex_takb;
`ifdef THOR2022_BUQ_STATS_EN
    w_wdata.pred = ex_pred;
`endif
  end

`ifndef THOR2022_BUQ_STATS_EN
  logic w_unused_ex_pred;
  assign w_unused_ex_pred = ex_pred;
`endif

  Thor2022_buq_ram #(
    .DEPTH (DEPTH),
    .AW    (CW - 1)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_enq),
    .i_waddr (r_tl[CW-2:0]),
    .i_wdata (w_wdata),
    .i_raddr (r_hd[CW-2:0]),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_hd      <= '0;
      r_cp      <= '0;
      r_tl      <= '0;
      xisBranch <= 1'b0;
      xip       <= '0;
      takb      <= 1'b0;
    end else begin
      r_cp <= w_cp_nxt;
      // Flush rewinds tl to the commit point after this cycle's commit.
      if (flush) begin
        r_tl <= w_cp_nxt;
      end else if (w_enq) begin
        r_tl <= r_tl + PTR_ONE;
      end
      if (w_drain) begin
        r_hd <= r_hd + PTR_ONE;
        xip  <= w_rdata.ip;
        takb <= w_rdata.takb;
      end
      xisBranch <= w_drain;
    end
  end

`ifdef THOR2022_BUQ_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      upd_cnt  <= '0;
      miss_cnt <= '0;
    end else if (w_drain) begin
      upd_cnt <= upd_cnt + 32'd1;
      if (w_rdata.pred != w_rdata.takb) begin
        miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_thor2022_branch_update_queue.sv
module tb_thor2022_branch_update_queue;
  import Thor2022_pkg::*;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          ex_v;
  Address        ex_ip;
  logic          ex_takb;
  logic          ex_pred;
  logic          ex_rdy;
  logic          cmt;
  logic          flush;
  logic          xisBranch;
  Address        xip;
  logic          takb;
  logic [CW-1:0] count;
`ifdef THOR2022_BUQ_STATS_EN
  logic [31:0]   upd_cnt;
  logic [31:0]   miss_cnt;
`endif

  always #5 clk = ~clk;

  thor2022_branch_update_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .ex_v      (ex_v),
    .ex_ip     (ex_ip),
    .ex_takb   (ex_takb),
    .ex_pred   (ex_pred),
    .ex_rdy    (ex_rdy),
    .cmt       (cmt),
    .flush     (flush),
    .xisBranch (xisBranch),
    .xip       (xip),
    .takb      (takb),
    .count     (count)
`ifdef THOR2022_BUQ_STATS_EN
    ,
    .upd_cnt   (upd_cnt),
    .miss_cnt  (miss_cnt)
`endif
  );

  typedef struct {
    logic [31:0] ip;
    logic        takb;
    logic        pred;
  } ent_t;

  // Reference: speculative entries and committed-but-undelivered entries.
  ent_t spec_q[$];
  ent_t cmt_q[$];
  logic        exp_strobe;
  logic [31:0] exp_ip;
  logic        exp_takb;
  int          exp_upd;
  int          exp_miss;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_in(input logic r, input logic e, input logic v, input logic [31:0] ip,
                        input logic tk, input logic pr, input logic c, input logic f);
    rst = r; en = e; ex_v = v; ex_ip = ip; ex_takb = tk; ex_pred = pr; cmt = c; flush = f;
  endtask

  // One clock: advance the reference from the inputs now applied, then compare.
  task automatic step();
    ent_t d;
    bit   drain;
    bit   do_enq;
    int   occ;
    if (!rst) begin
      spec_q.delete();
      cmt_q.delete();
      exp_strobe = 1'b0;
      exp_ip     = '0;
      exp_takb   = 1'b0;
      exp_upd    = 0;
      exp_miss   = 0;
    end else begin
      occ    = spec_q.size() + cmt_q.size();
      drain  = en && (cmt_q.size() > 0);
      do_enq = ex_v && (occ < DEPTH) && !flush;
      if (drain) d = cmt_q.pop_front();
      if (cmt && spec_q.size() > 0) cmt_q.push_back(spec_q.pop_front());
      if (flush) spec_q.delete();
      if (do_enq) spec_q.push_back('{ex_ip, ex_takb, ex_pred});
      exp_strobe = drain;
      if (drain) begin
        exp_ip   = d.ip;
        exp_takb = d.takb;
        exp_upd++;
        if (d.pred != d.takb) exp_miss++;
      end
    end
    @(posedge clk);
    #1;
    chk("strobe", 32'(xisBranch), 32'(exp_strobe));
    chk("xip", xip, exp_ip);
    chk("takb", 32'(takb), 32'(exp_takb));
    chk("count", 32'(count), 32'(spec_q.size() + cmt_q.size()));
    chk("ex_rdy", 32'(ex_rdy), 32'((spec_q.size() + cmt_q.size()) < DEPTH));
`ifdef THOR2022_BUQ_STATS_EN
    chk("upd_cnt", upd_cnt, 32'(exp_upd));
    chk("miss_cnt", miss_cnt, 32'(exp_miss));
`endif
  endtask

  task automatic idle(input logic e, input int n);
    for (int i = 0; i < n; i++) begin
      set_in(1, e, 0, '0, 0, 0, 0, 0);
      step();
    end
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, '0, 0, 0, 0, 0);
    step();
    step();
  endtask

  task automatic enq(input logic e, input logic [31:0] ip, input logic tk, input logic pr);
    set_in(1, e, 1, ip, tk, pr, 0, 0);
    step();
  endtask

  initial begin
    set_in(0, 0, 0, '0, 0, 0, 0, 0);
    // Scenario: single entry, commit, drain two cycles after enqueue.
    do_reset();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_rdy", 32'(ex_rdy), 32'd1);
    enq(1, 32'h100, 1, 1);
    set_in(1, 1, 0, '0, 0, 0, 1, 0);
    step();
    chk("t1_no_early", 32'(xisBranch), 32'd0);
    idle(1, 1);
    chk("t1_strobe", 32'(xisBranch), 32'd1);
    chk("t1_xip", xip, 32'h100);
    chk("t1_count", 32'(count), 32'd0);
    idle(1, 2);

    // Scenario: fill, drop overflow, then one commit + drain frees a slot.
    do_reset();
    for (int i = 0; i < DEPTH; i++) enq(1, 32'h200 + 32'(i * 4), i[0], 0);
    chk("t2_full_rdy", 32'(ex_rdy), 32'd0);
    chk("t2_full_cnt", 32'(count), 32'(DEPTH));
    enq(1, 32'hDEAD, 1, 1);
    chk("t2_drop_cnt", 32'(count), 32'(DEPTH));
    set_in(1, 1, 0, '0, 0, 0, 1, 0);
    step();
    idle(1, 1);
    chk("t2_rdy_back", 32'(ex_rdy), 32'd1);
    set_in(1, 1, 0, '0, 0, 0, 0, 1);
    step();
    idle(1, 2);

    // Scenario: A,B,C; commit once; flush -> only A delivered.
    do_reset();
    enq(1, 32'hA0, 1, 0);
    enq(1, 32'hB0, 0, 0);
    enq(1, 32'hC0, 1, 0);
    set_in(1, 1, 0, '0, 0, 0, 1, 0);
    step();
    set_in(1, 1, 0, '0, 0, 0, 0, 1);
    step();
    chk("t3_xip_a", xip, 32'hA0);
    idle(1, 3);
    chk("t3_count", 32'(count), 32'd0);
    chk("t3_hold_a", xip, 32'hA0);

    // Scenario: commit and flush together with A,B uncommitted.
    do_reset();
    enq(1, 32'hA4, 0, 1);
    enq(1, 32'hB4, 1, 1);
    set_in(1, 1, 0, '0, 0, 0, 1, 1);
    step();
    idle(1, 3);
    chk("t4_xip_a", xip, 32'hA4);

    // Scenario: en low holds three committed entries, then they stream out.
    do_reset();
    enq(0, 32'h10, 1, 1);
    enq(0, 32'h20, 0, 1);
    enq(0, 32'h30, 1, 0);
    for (int i = 0; i < 3; i++) begin
      set_in(1, 0, 0, '0, 0, 0, 1, 0);
      step();
    end
    idle(0, 3);
    chk("t5_stall_cnt", 32'(count), 32'd3);
    idle(1, 1);
    chk("t5_first", xip, 32'h10);
    idle(1, 1);
    chk("t5_second", xip, 32'h20);
    idle(1, 1);
    chk("t5_third", xip, 32'h30);
    idle(1, 2);

`ifdef THOR2022_BUQ_STATS_EN
    do_reset();
    enq(1, 32'h40, 1, 1);
    enq(1, 32'h44, 0, 0);
    enq(1, 32'h48, 1, 0);
    enq(1, 32'h4C, 0, 0);
    for (int i = 0; i < 4; i++) begin
      set_in(1, 1, 0, '0, 0, 0, 1, 0);
      step();
    end
    idle(1, 3);
    chk("t6_upd", upd_cnt, 32'd4);
    chk("t6_miss", miss_cnt, 32'd1);
    do_reset();
    chk("t6_upd_rst", upd_cnt, 32'd0);
    chk("t6_miss_rst", miss_cnt, 32'd0);
`endif

    // Randomized traffic including mid-run resets.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      set_in(($urandom_range(0, 199) != 0),
             ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 2) != 0),
             $urandom,
             1'($urandom),
             1'($urandom),
             ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 24) == 0));
      step();
    end
    idle(1, DEPTH + 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
